// File: rtl/instruction_sequencer.sv
// Fetch/sequence front end of the 16-bit SIMPLE core: owns PC and IR, fetches over a
// req/ack port, steps the five phases P1..P5 and resolves branches and HLT at writeback.
module instruction_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 32
) (
    input  logic             CLOCK,
    input  logic             RESET,
    output logic             imem_req,
    output logic [15:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [15:0]      imem_rdata,
    input  logic             dmem_busy,
    input  logic [3:0]       SZCV,
    input  logic             run,
    output logic [15:0]      COMMAND,
    output logic [15:0]      PC,
    output logic [4:0]       phase,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH, S_DEC, S_EXE, S_MEM, S_WB, S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic        is_hlt, is_b, is_bcc, cond_ok, take;
    logic        flag_s, flag_z, flag_v;
    logic [15:0] disp;

    // Carry is not used by any branch condition.
    logic unused_carry;
    assign unused_carry = SZCV[1];

    assign flag_s = SZCV[3];
    assign flag_z = SZCV[2];
    assign flag_v = SZCV[0];

    assign is_hlt = (ir_q[15:14] == 2'b11) && (ir_q[7:4] == 4'hF);
    assign is_b   = (ir_q[15:11] == 5'b10100);
    assign is_bcc = (ir_q[15:11] == 5'b10111);
    assign disp   = {{8{ir_q[7]}}, ir_q[7:0]};

    always_comb begin
        cond_ok = 1'b0;
        case (ir_q[10:8])
            3'b000:  cond_ok = flag_z;
            3'b001:  cond_ok = flag_s ^ flag_v;
            3'b010:  cond_ok = flag_z | (flag_s ^ flag_v);
            3'b011:  cond_ok = ~flag_z;
            default: cond_ok = 1'b0;
        endcase
    end

    assign take = is_b | (is_bcc & cond_ok);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ret_d   = ret_q;
        case (state_q)
            S_FETCH: if (imem_ack) begin
                ir_d    = imem_rdata;
                state_d = S_DEC;
            end
            S_DEC: state_d = S_EXE;
            S_EXE: state_d = S_MEM;
            S_MEM: if (!dmem_busy) state_d = S_WB;
            S_WB: begin
                ret_d   = ret_q + CNT_W'(1);
                pc_d    = take ? (pc_q + 16'd1 + disp) : (pc_q + 16'd1);
                state_d = is_hlt ? S_HALT : S_FETCH;
            end
            S_HALT: if (run) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ret_q   <= ret_d;
        end
    end

    // Outputs are masked while reset is held so nothing downstream sees a stray fetch.
    always_comb begin
        phase = 5'b00000;
        if (RESET) begin
            case (state_q)
                S_FETCH: phase = 5'b00001;
                S_DEC:   phase = 5'b00010;
                S_EXE:   phase = 5'b00100;
                S_MEM:   phase = 5'b01000;
                S_WB:    phase = 5'b10000;
                default: phase = 5'b00000;
            endcase
        end
    end

    assign imem_req  = (state_q == S_FETCH) & RESET;
    assign imem_addr = pc_q;
    assign halted    = (state_q == S_HALT) & RESET;
    assign COMMAND   = ir_q;
    assign PC        = pc_q;
    assign retired   = ret_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: inputs change and outputs are sampled on negedge.
module tb_instruction_sequencer;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        dmem_busy = 1'b0;
    logic [3:0]  SZCV = 4'h0;
    logic        run = 1'b0;
    logic [15:0] COMMAND;
    logic [15:0] PC;
    logic [4:0]  phase;
    logic        halted;
    logic [31:0] retired;

    int nchk = 0;
    int nerr = 0;

    instruction_sequencer #(.RESET_PC(16'h0000), .CNT_W(32)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_busy(dmem_busy), .SZCV(SZCV), .run(run),
        .COMMAND(COMMAND), .PC(PC), .phase(phase),
        .halted(halted), .retired(retired)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge CLOCK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at a negedge with RESET just released and the core in FETCH.
    task automatic do_reset();
        RESET = 1'b0; imem_ack = 1'b0; run = 1'b0; dmem_busy = 1'b0;
        repeat (2) cyc();
        RESET = 1'b1;
    endtask

    // Starts at a negedge in FETCH, acks at once, ends at the negedge after WB.
    task automatic exec(input logic [15:0] w);
        imem_ack = 1'b1; imem_rdata = w;
        cyc();
        imem_ack = 1'b0; imem_rdata = 16'hDEAD;
        repeat (4) cyc();
    endtask

    initial begin
        logic [15:0] exp_pc;
        logic        tk;
        logic [2:0]  c3;
        logic [3:0]  f4;

        // 1: reset state, then HLT with single-cycle ack
        repeat (2) cyc();
        chk("rst_req", imem_req, 0);
        chk("rst_phase", phase, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", PC, 16'h0000);
        chk("rst_ir", COMMAND, 16'h0000);
        chk("rst_retired", retired, 0);
        RESET = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hC0F0;
        #1;
        chk("t1_p1", phase, 5'b00001);
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 16'h0000);
        cyc(); imem_ack = 1'b0;
        chk("t1_ir", COMMAND, 16'hC0F0);
        chk("t1_p2", phase, 5'b00010);
        cyc(); chk("t1_p3", phase, 5'b00100);
        cyc(); chk("t1_p4", phase, 5'b01000);
        cyc(); chk("t1_p5", phase, 5'b10000);
        cyc();
        chk("t1_halted", halted, 1);
        chk("t1_phase0", phase, 0);
        chk("t1_pc", PC, 16'h0001);
        chk("t1_retired", retired, 1);
        chk("t1_noreq", imem_req, 0);
        repeat (3) cyc();
        chk("t1_hold_pc", PC, 16'h0001);
        chk("t1_hold_ret", retired, 1);
        chk("t1_hold_halt", halted, 1);

        // 2: ack delayed by three cycles; stray ack outside FETCH and run outside HALT
        do_reset();
        imem_rdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t2_req%0d", i), imem_req, 1);
            chk($sformatf("t2_addr%0d", i), imem_addr, 16'h0000);
            chk($sformatf("t2_ir%0d", i), COMMAND, 16'h0000);
            cyc();
        end
        imem_ack = 1'b1; imem_rdata = 16'h1234;
        #1;
        chk("t2_req3", imem_req, 1);
        chk("t2_addr3", imem_addr, 16'h0000);
        cyc(); imem_ack = 1'b0;
        chk("t2_ir", COMMAND, 16'h1234);
        chk("t2_p2", phase, 5'b00010);
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        cyc(); imem_ack = 1'b0;
        chk("t2_stray_ack", COMMAND, 16'h1234);
        chk("t2_p3", phase, 5'b00100);
        run = 1'b1;
        cyc(); run = 1'b0;
        chk("t2_run_ignored", phase, 5'b01000);
        repeat (2) cyc();
        chk("t2_next_addr", imem_addr, 16'h0001);
        chk("t2_retired", retired, 1);
        chk("t2_not_halted", halted, 0);

        // 3: unconditional branches, including wrap through 16'hFFFF
        do_reset();
        exec(16'hA00F); chk("t3_fwd", imem_addr, 16'h0010);
        exec(16'hA0FE); chk("t3_back", imem_addr, 16'h000F);
        do_reset();
        exec(16'hA0FE); chk("t3_wrap_lo", imem_addr, 16'hFFFF);
        exec(16'hA001); chk("t3_wrap_hi", imem_addr, 16'h0001);

        // 4: Bcc sweep at PC=5 with d=4
        do_reset();
        exec(16'hA004); chk("t4_setup", imem_addr, 16'h0005);
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 16; f++) begin
                c3 = c[2:0]; f4 = f[3:0];
                case (c3)
                    3'b000:  tk = f4[2];
                    3'b001:  tk = f4[3] ^ f4[0];
                    3'b010:  tk = f4[2] | (f4[3] ^ f4[0]);
                    3'b011:  tk = ~f4[2];
                    default: tk = 1'b0;
                endcase
                exp_pc = tk ? 16'd10 : 16'd6;
                SZCV = f4;
                exec({5'b10111, c3, 8'h04});
                chk($sformatf("t4_bcc c%0d f%0h", c, f), imem_addr, exp_pc);
                exec(tk ? 16'hA0FA : 16'hA0FE);
            end
        end
        SZCV = 4'h0;

        // 5: data-memory stall holds P4 for three cycles
        do_reset();
        imem_ack = 1'b1; imem_rdata = 16'h0000;
        cyc(); imem_ack = 1'b0;
        cyc(); dmem_busy = 1'b1;
        cyc(); chk("t5_p4a", phase, 5'b01000);
        cyc(); chk("t5_p4b", phase, 5'b01000);
        cyc(); chk("t5_p4c", phase, 5'b01000);
        dmem_busy = 1'b0;
        cyc();
        chk("t5_p5", phase, 5'b10000);
        chk("t5_ret_before", retired, 0);
        cyc();
        chk("t5_ret_after", retired, 1);
        chk("t5_addr", imem_addr, 16'h0001);
        chk("t5_p1", phase, 5'b00001);

        // 6: reset during FETCH with a same-cycle ack, then HALT and resume
        do_reset();
        exec(16'hA00F);
        chk("t6_pre_pc", PC, 16'h0010);
        RESET = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h1234;
        #1;
        chk("t6_req_masked", imem_req, 0);
        chk("t6_phase_masked", phase, 0);
        cyc(); imem_ack = 1'b0;
        chk("t6_ir", COMMAND, 16'h0000);
        chk("t6_pc", PC, 16'h0000);
        chk("t6_retired", retired, 0);
        RESET = 1'b1;
        exec(16'hC0F0);
        chk("t6_halted", halted, 1);
        chk("t6_halt_pc", PC, 16'h0001);
        cyc();
        chk("t6_hold_pc", PC, 16'h0001);
        run = 1'b1;
        cyc(); run = 1'b0;
        chk("t6_resume_req", imem_req, 1);
        chk("t6_resume_addr", imem_addr, 16'h0001);
        chk("t6_resume_phase", phase, 5'b00001);
        chk("t6_resume_halted", halted, 0);
        chk("t6_resume_ret", retired, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
